call_stack_ctl: RTL

- Return-address stack controller driven by the jump decoder's pushCallStack/popCallStack outputs.
- Owns a circular stack of return addresses and supplies the predicted return target on pop.
- Checkpoints stack state per branch tag and restores it on mispredict flush.
- Sits between the decode stage and the fetch predictor.

---
 rtl/call_stack_ctl_pkg.sv | 28 ++
 rtl/call_stack_ctl_ram.sv | 23 ++
 rtl/call_stack_ctl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/call_stack_ctl_pkg.sv
// Shared types for the return-address stack: FSM states and the checkpoint record.
// Default sizes come from CS_DEPTH / CS_CHK_NUM and may be overridden on the command line.
`ifndef CS_DEPTH
`define CS_DEPTH 16
`endif
`ifndef CS_CHK_NUM
`define CS_CHK_NUM 4
`endif

package call_stack_ctl_pkg;

  localparam int CS_DEPTH   = `CS_DEPTH;
  localparam int CS_CHK_NUM = `CS_CHK_NUM;
  localparam int CS_PTR_W   = $clog2(CS_DEPTH);
  localparam int CS_CNT_W   = $clog2(CS_DEPTH + 1);

  typedef enum logic {
    CS_NORMAL  = 1'b0,
    CS_RECOVER = 1'b1
  } cs_state_e;

  typedef struct packed {
    logic [CS_PTR_W-1:0] tos;
    logic [CS_CNT_W-1:0] count;
    logic                valid;
  } cs_chk_t;

endpackage

// File: rtl/call_stack_ctl_ram.sv
// Return-address storage: one synchronous write port, one asynchronous read port.
module call_stack_ctl_ram #(
  parameter int DEPTH    = 16,
  parameter int IP_WIDTH = 64,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [PTR_W-1:0]    waddr,
  input  logic [IP_WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]    raddr,
  output logic [IP_WIDTH-1:0] rdata
);

  logic [IP_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack_ctl.sv
// Return-address stack controller with per-branch-tag checkpoint/restore of {tos,count}.
// Define CALL_STACK_PERF_EN to add saturating overflow/underflow counters (ovf_cnt, unf_cnt).
module call_stack_ctl
  import call_stack_ctl_pkg::*;
#(
  parameter int DEPTH    = CS_DEPTH,
  parameter int IP_WIDTH = 64,
  parameter int CHK_NUM  = CS_CHK_NUM,
  localparam int ID_W    = (CHK_NUM > 1) ? $clog2(CHK_NUM) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [IP_WIDTH-1:0] push_addr,
  input  logic                pop,
  output logic [IP_WIDTH-1:0] pop_addr,
  output logic                pop_hit,
  input  logic                snap,
  input  logic [ID_W-1:0]     snap_id,
  input  logic                restore,
  input  logic [ID_W-1:0]     rest_id,
  output logic                busy,
  output logic                empty,
  output logic                full
`ifdef CALL_STACK_PERF_EN
  ,
  output logic [15:0]         ovf_cnt,
  output logic [15:0]         unf_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  cs_state_e           state_q, state_nx;
  logic [PTR_W-1:0]    tos_q, tos_nx, top_idx;
  logic [CNT_W-1:0]    cnt_q, cnt_nx;
  logic [ID_W-1:0]     rest_q, rest_nx;
  cs_chk_t             chk_q [CHK_NUM];
  cs_chk_t             chk_rd;
  logic                nonempty, active, do_push, do_pop, snap_we;
  logic                ram_we;
  logic [PTR_W-1:0]    ram_waddr;
  logic [IP_WIDTH-1:0] ram_rdata;

  assign nonempty = (cnt_q != '0);
  assign top_idx  = tos_q - 1'b1;
  // Restore wins over everything in the same cycle; RECOVER blocks the decoder.
  assign active   = (state_q == CS_NORMAL) && !restore;
  assign do_push  = active && push;
  assign do_pop   = active && pop;
  assign chk_rd   = chk_q[rest_q];

  // Push+pop with a live top replaces the top entry in place.
  assign ram_we    = do_push;
  assign ram_waddr = (do_pop && nonempty) ? top_idx : tos_q;

  call_stack_ctl_ram #(
    .DEPTH   (DEPTH),
    .IP_WIDTH(IP_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(push_addr),
    .raddr(top_idx),
    .rdata(ram_rdata)
  );

  assign pop_addr = nonempty ? ram_rdata : '0;
  assign pop_hit  = do_pop && nonempty;
  assign busy     = (state_q == CS_RECOVER);
  assign empty    = !nonempty;
  assign full     = (cnt_q == CNT_W'(DEPTH));

  always_comb begin
    state_nx = state_q;
    tos_nx   = tos_q;
    cnt_nx   = cnt_q;
    rest_nx  = rest_q;
    snap_we  = 1'b0;
    if (state_q == CS_RECOVER) begin
      if (restore) begin
        rest_nx = rest_id;
      end else begin
        state_nx = CS_NORMAL;
        if (chk_rd.valid) begin
          tos_nx = PTR_W'(chk_rd.tos);
          cnt_nx = CNT_W'(chk_rd.count);
        end else begin
          tos_nx = '0;
          cnt_nx = '0;
        end
      end
    end else if (restore) begin
      state_nx = CS_RECOVER;
      rest_nx  = rest_id;
    end else begin
      if (push && !(pop && nonempty)) begin
        tos_nx = tos_q + 1'b1;
        if (!full) cnt_nx = cnt_q + 1'b1;
      end else if (!push && pop && nonempty) begin
        tos_nx = tos_q - 1'b1;
        cnt_nx = cnt_q - 1'b1;
      end
      snap_we = snap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CS_NORMAL;
      tos_q   <= '0;
      cnt_q   <= '0;
      rest_q  <= '0;
    end else begin
      state_q <= state_nx;
      tos_q   <= tos_nx;
      cnt_q   <= cnt_nx;
      rest_q  <= rest_nx;
    end
  end

  // Only the valid bits are reset; tos/count payload is don't-care until written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHK_NUM; i++) chk_q[i].valid <= 1'b0;
    end else if (snap_we) begin
      chk_q[snap_id] <= '{tos: CS_PTR_W'(tos_nx), count: CS_CNT_W'(cnt_nx), valid: 1'b1};
    end
  end

`ifdef CALL_STACK_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (do_push && !do_pop && full && ovf_cnt != 16'hffff) ovf_cnt <= ovf_cnt + 16'd1;
      if (do_pop && !nonempty && unf_cnt != 16'hffff)        unf_cnt <= unf_cnt + 16'd1;
    end
  end
`endif

endmodule
